inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter A, default 10: instruction address width, program space 2**A words.
REQ-002 Parameter OW, default 8: signed relative branch offset width, OW <= A.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  level request to begin execution at StartAddr.
REQ-006 StartAddr  input  A  program entry address, sampled on the IDLE/HALT->RUN transition.
REQ-007 Stall  input  1  hold ProgCtr for this cycle (downstream not ready).
REQ-008 BranchAbs  input  1  load ProgCtr from Target.
REQ-009 Target  input  A  absolute branch destination.
REQ-010 BranchRel  input  1  add signed Offset to ProgCtr.
REQ-011 Offset  input  OW  two's-complement relative displacement.
REQ-012 Halt  input  1  decoded halt instruction; ends the program.
REQ-013 ProgCtr  output  A  registered instruction address, drives the instruction ROM InstAddress.
REQ-014 FetchValid  output  1  high while ProgCtr addresses an instruction to be executed.
REQ-015 Ack  output  1  program-complete flag.
REQ-016 InstCount  output  16  count of advanced (non-stalled) RUN cycles in the current program.

Function
REQ-017 States IDLE, RUN, HALT; the module SHALL hold exactly one at a time.
REQ-018 IDLE: ProgCtr held, FetchValid=0, Ack=0; Start=1 -> RUN, ProgCtr<=StartAddr, InstCount<=0.
REQ-019 RUN: FetchValid=1 combinationally from state; next ProgCtr by priority Halt > Stall > BranchAbs > BranchRel > ProgCtr+1.
REQ-020 Halt=1 in RUN -> HALT next cycle; ProgCtr held; InstCount unchanged.
REQ-021 Stall=1 (no Halt): ProgCtr and InstCount held; branch inputs ignored that cycle.
REQ-022 BranchAbs=1: ProgCtr<=Target; if BranchRel also 1, BranchRel ignored.
REQ-023 BranchRel=1: ProgCtr<=ProgCtr+sign-extend(Offset), result modulo 2**A.
REQ-024 Increment SHALL wrap modulo 2**A: ProgCtr=2**A-1 advances to 0, no error flag.
REQ-025 InstCount SHALL increment by 1 on each RUN cycle that is not stalled and not halting; saturate at 16'hFFFF.
REQ-026 Start while in RUN SHALL be ignored (no restart).
REQ-027 HALT: Ack=1, FetchValid=0, ProgCtr and InstCount held; Start=1 -> RUN with ProgCtr<=StartAddr, InstCount<=0, Ack<=0 next cycle.
REQ-028 Ack SHALL be registered, asserted the cycle after Halt is sampled.
REQ-029 Latency: control inputs sampled at edge N affect ProgCtr at edge N (visible cycle N+1); no combinational input-to-output paths except none.

Reset
REQ-030 Reset_n=0 SHALL asynchronously force state=IDLE, ProgCtr=0, Ack=0, InstCount=0, FetchValid=0.
REQ-031 Reset mid-RUN or mid-HALT SHALL abort immediately; no pending branch survives.
REQ-032 After Reset_n rises, module SHALL remain IDLE until Start is sampled high.

Structure
REQ-033 Shared package fetch_pkg SHALL hold the state enum (IDLE, RUN, HALT) and default widths A=10, OW=8, count width 16.
REQ-034 Next-PC selection SHALL live in one combinational sub-module pc_next (inputs ProgCtr, Stall, BranchAbs, Target, BranchRel, Offset; output next address); state machine and registers in inst_fetch.

Verification
REQ-035 Reset_n low, then Start=1 StartAddr=10'd5 -> ProgCtr 5,6,7,8 on successive cycles, FetchValid=1, InstCount 0,1,2,3.
REQ-036 In RUN at ProgCtr=20, BranchRel=1 Offset=8'hFC -> next ProgCtr=16; BranchAbs=1 Target=300 together with BranchRel -> ProgCtr=300.
REQ-037 StartAddr=10'h3FE, run 3 cycles -> ProgCtr 3FE,3FF,000,001 (wrap); Offset=8'h7F at ProgCtr=3F0 -> 06F.
REQ-038 Stall=1 for 2 cycles with BranchAbs=1 -> ProgCtr and InstCount frozen, branch not taken; Halt=1 with Stall=1 -> HALT, Ack=1 next cycle.
REQ-039 Reset_n pulsed low mid-RUN at ProgCtr=40 -> same-cycle ProgCtr=0, Ack=0, state IDLE; Start in HALT restarts at StartAddr with InstCount=0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and default widths for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned ADDR_W = 10;  // instruction address width
  localparam int unsigned OFF_W  = 8;   // signed relative branch offset width
  localparam int unsigned CNT_W  = 16;  // advanced-instruction counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Control/status bundle between the decode stage and the fetch unit.
// slave : fetch unit (consumes Start/StartAddr/Stall/branches/Halt,
//         produces ProgCtr/FetchValid/Ack/InstCount)
// master: decode/controller side (the mirror image)
interface inst_fetch_if
  import fetch_pkg::*;
#(
  parameter int unsigned A  = ADDR_W,
  parameter int unsigned OW = OFF_W
) ();

  logic             Start;
  logic [A-1:0]     StartAddr;
  logic             Stall;
  logic             BranchAbs;
  logic [A-1:0]     Target;
  logic             BranchRel;
  logic [OW-1:0]    Offset;
  logic             Halt;
  logic [A-1:0]     ProgCtr;
  logic             FetchValid;
  logic             Ack;
  logic [CNT_W-1:0] InstCount;

  modport slave (
    input  Start, StartAddr, Stall, BranchAbs, Target, BranchRel, Offset, Halt,
    output ProgCtr, FetchValid, Ack, InstCount
  );

  modport master (
    output Start, StartAddr, Stall, BranchAbs, Target, BranchRel, Offset, Halt,
    input  ProgCtr, FetchValid, Ack, InstCount
  );

endinterface

// File: rtl/inst_fetch_pc_next.sv
// Combinational next-PC selection for the RUN state.
// Priority: Stall (hold) > BranchAbs (Target) > BranchRel (PC+sext(Offset)) > PC+1.
// All arithmetic wraps modulo 2**A.
// Ports: ProgCtr_i, Stall_i, BranchAbs_i, Target_i, BranchRel_i, Offset_i -> next_pc_c_o
module pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned A  = ADDR_W,
  parameter int unsigned OW = OFF_W
) (
  input  logic [A-1:0]  ProgCtr_i,
  input  logic          Stall_i,
  input  logic          BranchAbs_i,
  input  logic [A-1:0]  Target_i,
  input  logic          BranchRel_i,
  input  logic [OW-1:0] Offset_i,
  output logic [A-1:0]  next_pc_c_o
);

  logic [A-1:0] offset_sext;

  // Signed cast so the width extension replicates the sign bit
  assign offset_sext = A'($signed(Offset_i));

  always_comb begin
    next_pc_c_o = ProgCtr_i + A'(1);
    if (Stall_i) begin
      next_pc_c_o = ProgCtr_i;
    end else if (BranchAbs_i) begin
      next_pc_c_o = Target_i;
    end else if (BranchRel_i) begin
      next_pc_c_o = ProgCtr_i + offset_sext;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch sequencer: IDLE/RUN/HALT state machine owning the program
// counter, program-complete flag and advanced-instruction counter.
// Ports: Clk, Reset_n (async active-low), bus (inst_fetch_if.slave):
//   Start/StartAddr launch a program from IDLE or HALT, Stall/BranchAbs/
//   BranchRel/Halt steer the PC in RUN, ProgCtr/FetchValid/Ack/InstCount
//   are all registered.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned A  = ADDR_W,
  parameter int unsigned OW = OFF_W
) (
  input  logic          Clk,
  input  logic          Reset_n,
  inst_fetch_if.slave   bus
);

  state_e           state_q, state_d;
  logic [A-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             fv_q, fv_d;
  logic [A-1:0]     pc_run_c;

  pc_next #(.A(A), .OW(OW)) u_pc_next (
    .ProgCtr_i   (pc_q),
    .Stall_i     (bus.Stall),
    .BranchAbs_i (bus.BranchAbs),
    .Target_i    (bus.Target),
    .BranchRel_i (bus.BranchRel),
    .Offset_i    (bus.Offset),
    .next_pc_c_o (pc_run_c)
  );

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      fv_q    <= fv_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (bus.Start) begin
          state_d = RUN;
          pc_d    = bus.StartAddr;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Halt wins over everything, including Stall; Start is ignored here
        if (bus.Halt) begin
          state_d = HALT;
        end else begin
          pc_d = pc_run_c;
          if (!bus.Stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Flags are decoded from the upcoming state so they register alongside it
    fv_d  = (state_d == RUN);
    ack_d = (state_d == HALT);
  end

  assign bus.ProgCtr    = pc_q;
  assign bus.FetchValid = fv_q;
  assign bus.Ack        = ack_q;
  assign bus.InstCount  = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch.
module tb_inst_fetch;

  logic Clk;
  logic Reset_n;
  int   checks;
  int   errors;

  inst_fetch_if #(.A(10), .OW(8)) bus ();

  inst_fetch #(.A(10), .OW(8)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [9:0] pc, input logic fv,
                         input logic ack, input logic [15:0] cnt);
    chk({tag, ".pc"},  32'(bus.ProgCtr),    32'(pc));
    chk({tag, ".fv"},  32'(bus.FetchValid), 32'(fv));
    chk({tag, ".ack"}, 32'(bus.Ack),        32'(ack));
    chk({tag, ".cnt"}, 32'(bus.InstCount),  32'(cnt));
  endtask

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    bus.Start     = 1'b0;
    bus.Stall     = 1'b0;
    bus.BranchAbs = 1'b0;
    bus.BranchRel = 1'b0;
    bus.Halt      = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr();
    bus.StartAddr = '0;
    bus.Target    = '0;
    bus.Offset    = '0;
    Reset_n       = 1'b0;
    #3;
    chk_all("reset", 10'd0, 1'b0, 1'b0, 16'd0);
    #10;
    Reset_n = 1'b1;

    // Stays idle without Start
    step();
    step();
    chk_all("idle", 10'd0, 1'b0, 1'b0, 16'd0);

    // Start at 5, sequential advance
    bus.Start = 1'b1; bus.StartAddr = 10'd5;
    step();
    clr();
    chk_all("start", 10'd5, 1'b1, 1'b0, 16'd0);
    step(); chk_all("seq1", 10'd6, 1'b1, 1'b0, 16'd1);
    step(); chk_all("seq2", 10'd7, 1'b1, 1'b0, 16'd2);
    step(); chk_all("seq3", 10'd8, 1'b1, 1'b0, 16'd3);

    // Absolute to 20, relative -4, then Abs beats Rel
    bus.BranchAbs = 1'b1; bus.Target = 10'd20;
    step(); clr();
    chk_all("abs20", 10'd20, 1'b1, 1'b0, 16'd4);
    bus.BranchRel = 1'b1; bus.Offset = 8'hFC;
    step(); clr();
    chk_all("relneg", 10'd16, 1'b1, 1'b0, 16'd5);
    bus.BranchAbs = 1'b1; bus.Target = 10'd300; bus.BranchRel = 1'b1; bus.Offset = 8'h10;
    step(); clr();
    chk_all("absprio", 10'd300, 1'b1, 1'b0, 16'd6);

    // Start in RUN is ignored
    bus.Start = 1'b1; bus.StartAddr = 10'd5;
    step(); clr();
    chk_all("norestart", 10'd301, 1'b1, 1'b0, 16'd7);

    // Stall two cycles with a branch pending: everything frozen
    bus.Stall = 1'b1; bus.BranchAbs = 1'b1; bus.Target = 10'd100;
    step(); chk_all("stall1", 10'd301, 1'b1, 1'b0, 16'd7);
    step(); chk_all("stall2", 10'd301, 1'b1, 1'b0, 16'd7);

    // Halt together with Stall
    bus.Halt = 1'b1;
    step(); clr();
    chk_all("halt", 10'd301, 1'b0, 1'b1, 16'd7);
    step(); chk_all("halthold", 10'd301, 1'b0, 1'b1, 16'd7);

    // Restart from HALT near the top of the address space; wraps
    bus.Start = 1'b1; bus.StartAddr = 10'h3FE;
    step(); clr();
    chk_all("restart", 10'h3FE, 1'b1, 1'b0, 16'd0);
    step(); chk_all("wrap1", 10'h3FF, 1'b1, 1'b0, 16'd1);
    step(); chk_all("wrap2", 10'h000, 1'b1, 1'b0, 16'd2);
    step(); chk_all("wrap3", 10'h001, 1'b1, 1'b0, 16'd3);

    // Positive relative branch wrapping past the top
    bus.BranchAbs = 1'b1; bus.Target = 10'h3F0;
    step(); clr();
    chk_all("abs3f0", 10'h3F0, 1'b1, 1'b0, 16'd4);
    bus.BranchRel = 1'b1; bus.Offset = 8'h7F;
    step(); clr();
    chk_all("relwrap", 10'h06F, 1'b1, 1'b0, 16'd5);

    // Reset mid-RUN with a branch pending
    bus.BranchAbs = 1'b1; bus.Target = 10'd40;
    step(); clr();
    chk_all("abs40", 10'd40, 1'b1, 1'b0, 16'd6);
    bus.BranchAbs = 1'b1; bus.Target = 10'd123;
    #2;
    Reset_n = 1'b0;
    #1;
    chk_all("midreset", 10'd0, 1'b0, 1'b0, 16'd0);
    #2;
    Reset_n = 1'b1;
    clr();
    step(); chk_all("postreset", 10'd0, 1'b0, 1'b0, 16'd0);

    // Run to HALT then restart clears the counter
    bus.Start = 1'b1; bus.StartAddr = 10'd50;
    step(); clr();
    step();
    chk_all("run51", 10'd51, 1'b1, 1'b0, 16'd1);
    bus.Halt = 1'b1;
    step(); clr();
    chk_all("halt2", 10'd51, 1'b0, 1'b1, 16'd1);
    bus.Start = 1'b1; bus.StartAddr = 10'd200;
    step(); clr();
    chk_all("restart2", 10'd200, 1'b1, 1'b0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
